fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameters: WIDTH, default 160, frame width in pixels; HEIGHT, default 120, frame height in pixels; ADDR_W, default 16, RAM address width, with WIDTH*HEIGHT <= 2^(ADDR_W-1).
REQ-002 SHALL have ports, one per line below.
REQ-003 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 disp_req  in  1  display read request for one pixel.
REQ-006 disp_x  in  10 / disp_y  in  9  display pixel coordinates.
REQ-007 disp_valid  out  1 / disp_rgb  out  24  display read response, {r,g,b}.
REQ-008 w0_req, w1_req  in  1  writer write requests.
REQ-009 w0_x, w1_x  in  10 / w0_y, w1_y  in  9 / w0_rgb, w1_rgb  in  24  writer coordinates and pixel.
REQ-010 w0_ready, w1_ready  out  1  combinational grant; a write transfers on an edge where req and ready are both 1.
REQ-011 swap_req  in  1  one-cycle pulse requesting a front/back buffer swap.
REQ-012 frame_end  in  1  one-cycle pulse at end of the active frame.
REQ-013 front  out  1 / swap_done  out  1  current display buffer; one-cycle pulse when a swap takes effect.
REQ-014 mem_addr  out  ADDR_W / mem_wdata  out  24 / mem_we  out  1  single-port RAM command, registered.
REQ-015 mem_rdata  in  24  RAM read data, valid the cycle after the address is presented.

Function
REQ-016 One RAM access per cycle; grant decided combinationally in cycle N from that cycle's requests.
REQ-017 Priority: disp_req always wins; w0_ready = w1_ready = 0 in any cycle with disp_req = 1.
REQ-018 Writers round-robin: if both request and no display, grant the writer not granted last; a single requester is granted immediately.
REQ-019 Round-robin pointer updates only on a writer grant; display grants and idle cycles leave it unchanged.
REQ-020 Pixel index = y*WIDTH + x, computed in ADDR_W-1 bits; mem_addr = {buffer bit, index}.
REQ-021 Display reads address buffer front; writes address buffer ~front.
REQ-022 Grant in cycle N drives mem_addr/mem_we/mem_wdata in cycle N+1; mem_we = 1 only for an in-range write grant, else 0.
REQ-023 Display read granted in cycle N: disp_valid = 1 and disp_rgb = registered mem_rdata in cycle N+3; fixed latency 3; back-to-back reads pipeline at one per cycle.
REQ-024 Out-of-range display read (x >= WIDTH or y >= HEIGHT): still issued as an access slot with mem_we = 0; response in N+3 with disp_valid = 1, disp_rgb = 0.
REQ-025 Out-of-range write: granted and acknowledged normally (ready = 1), mem_we = 0, no RAM change.
REQ-026 Swap FSM states: IDLE, PENDING.
REQ-027 IDLE: swap_req -> PENDING; frame_end alone -> stay.
REQ-028 PENDING: frame_end -> toggle front, swap_done = 1 for one cycle, -> IDLE; swap_req ignored.
REQ-029 swap_req and frame_end in the same IDLE cycle -> PENDING only; swap occurs on the next frame_end.
REQ-030 front changes only at the swap edge; reads issued before it complete from the old buffer.

Reset
REQ-031 reset_n = 0 asynchronously forces: mem_addr = 0, mem_wdata = 0, mem_we = 0, disp_valid = 0, disp_rgb = 0, front = 0, swap_done = 0, FSM = IDLE, round-robin pointer = w1 last (w0 wins first contest), read pipeline cleared.
REQ-032 Reads in flight when reset asserts are discarded; no disp_valid follows deassertion without a new request.

Verification
REQ-033 Display read x=3, y=2, WIDTH=160, front=0, mem_rdata=0xABCDEF in N+2 -> mem_addr=323 in N+1, disp_valid=1 and disp_rgb=0xABCDEF in N+3.
REQ-034 w0_req and w1_req held high, no display, 4 cycles -> grants w0,w1,w0,w1; mem_we=1 each cycle; addresses carry bit 15 = 1.
REQ-035 disp_req high 3 cycles with w0_req high -> w0_ready=0 for those cycles, granted on the first cycle disp_req=0.
REQ-036 w1 write x=160, y=0 -> w1_ready=1, mem_we=0 next cycle; display read x=0, y=120 -> disp_valid=1, disp_rgb=0.
REQ-037 swap_req and frame_end in same cycle, then frame_end 10 cycles later -> front toggles 0->1 only at second frame_end, swap_done one-cycle pulse there.
REQ-038 reset_n low mid-burst of 2 pending display reads -> all outputs 0 immediately; no disp_valid after release; next contest grants w0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Double-buffered frame-buffer arbiter: one single-port RAM shared by a display
// reader (highest priority) and two round-robin writers, with a frame-synchronous swap.
module fb_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [8:0]        disp_y,
  output logic              disp_valid,
  output logic [23:0]       disp_rgb,
  input  logic              w0_req,
  input  logic [9:0]        w0_x,
  input  logic [8:0]        w0_y,
  input  logic [23:0]       w0_rgb,
  output logic              w0_ready,
  input  logic              w1_req,
  input  logic [9:0]        w1_x,
  input  logic [8:0]        w1_y,
  input  logic [23:0]       w1_rgb,
  output logic              w1_ready,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              front,
  output logic              swap_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  output logic              mem_we,
  input  logic [23:0]       mem_rdata
);

  localparam int IDX_W = ADDR_W - 1;

  typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} swap_state_t;

  swap_state_t       state_r, state_nx_s;
  logic              swap_fire_s;
  logic              front_r, swap_done_r;
  logic              last_w1_r;
  logic              w0_gnt_s, w1_gnt_s, wr_gnt_s;
  logic [9:0]        sel_x_s;
  logic [8:0]        sel_y_s;
  logic [23:0]       sel_rgb_s;
  logic              sel_buf_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [23:0]       mem_wdata_r;
  logic              mem_we_r;
  logic              rd1_v_r, rd1_ok_r, rd2_v_r, rd2_ok_r;
  logic              disp_valid_r;
  logic [23:0]       disp_rgb_r;

  // Grant: display always wins; writers alternate when both request, last_w1_r = w1 granted last
  always_comb begin
    w0_gnt_s = 1'b0;
    w1_gnt_s = 1'b0;
    if (disp_req) begin
      w0_gnt_s = 1'b0;
      w1_gnt_s = 1'b0;
    end else if (w0_req && w1_req) begin
      w0_gnt_s = last_w1_r;
      w1_gnt_s = ~last_w1_r;
    end else begin
      w0_gnt_s = w0_req;
      w1_gnt_s = w1_req;
    end
  end

  assign wr_gnt_s = w0_gnt_s | w1_gnt_s;
  assign w0_ready = w0_gnt_s;
  assign w1_ready = w1_gnt_s;

  // Select the granted requester's coordinates, pixel and target buffer
  always_comb begin
    sel_x_s   = w1_x;
    sel_y_s   = w1_y;
    sel_rgb_s = w1_rgb;
    sel_buf_s = ~front_r;
    if (disp_req) begin
      sel_x_s   = disp_x;
      sel_y_s   = disp_y;
      sel_rgb_s = 24'd0;
      sel_buf_s = front_r;
    end else if (w0_gnt_s) begin
      sel_x_s   = w0_x;
      sel_y_s   = w0_y;
      sel_rgb_s = w0_rgb;
      sel_buf_s = ~front_r;
    end else begin
      sel_x_s   = w1_x;
      sel_y_s   = w1_y;
      sel_rgb_s = w1_rgb;
      sel_buf_s = ~front_r;
    end
  end

  assign in_range_s = (32'(sel_x_s) < 32'(WIDTH)) && (32'(sel_y_s) < 32'(HEIGHT));
  assign idx_s      = IDX_W'(sel_y_s) * IDX_W'(WIDTH) + IDX_W'(sel_x_s);

  // Registered RAM command, one access slot per cycle
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_r  <= '0;
      mem_wdata_r <= 24'd0;
      mem_we_r    <= 1'b0;
    end else begin
      if (disp_req || wr_gnt_s) begin
        mem_addr_r <= {sel_buf_s, idx_s};
      end else begin
        mem_addr_r <= mem_addr_r;
      end
      mem_we_r    <= wr_gnt_s & in_range_s;
      mem_wdata_r <= wr_gnt_s ? sel_rgb_s : 24'd0;
    end
  end

  // Read pipeline: address out N+1, RAM data N+2, registered response N+3
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd1_v_r      <= 1'b0;
      rd1_ok_r     <= 1'b0;
      rd2_v_r      <= 1'b0;
      rd2_ok_r     <= 1'b0;
      disp_valid_r <= 1'b0;
      disp_rgb_r   <= 24'd0;
    end else begin
      rd1_v_r      <= disp_req;
      rd1_ok_r     <= disp_req & in_range_s;
      rd2_v_r      <= rd1_v_r;
      rd2_ok_r     <= rd1_ok_r;
      disp_valid_r <= rd2_v_r;
      disp_rgb_r   <= rd2_ok_r ? mem_rdata : 24'd0;
    end
  end

  // Round-robin pointer moves only on writer grants
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      last_w1_r <= 1'b1;
    end else if (wr_gnt_s) begin
      last_w1_r <= w1_gnt_s;
    end else begin
      last_w1_r <= last_w1_r;
    end
  end

  // Swap FSM next state: a request waits for the following frame_end
  always_comb begin
    state_nx_s  = state_r;
    swap_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (swap_req) begin
          state_nx_s = PENDING;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PENDING: begin
        if (frame_end) begin
          state_nx_s  = IDLE;
          swap_fire_s = 1'b1;
        end else begin
          state_nx_s = PENDING;
        end
      end
      default: begin
        state_nx_s  = IDLE;
        swap_fire_s = 1'b0;
      end
    endcase
  end

  // Swap FSM state, front buffer and swap_done pulse
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      front_r     <= 1'b0;
      swap_done_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      front_r     <= front_r ^ swap_fire_s;
      swap_done_r <= swap_fire_s;
    end
  end

  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_we     = mem_we_r;
  assign disp_valid = disp_valid_r;
  assign disp_rgb   = disp_rgb_r;
  assign front      = front_r;
  assign swap_done  = swap_done_r;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter with a behavioural single-port RAM.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_req;
  logic [9:0]  disp_x;
  logic [8:0]  disp_y;
  logic        disp_valid;
  logic [23:0] disp_rgb;
  logic        w0_req, w1_req;
  logic [9:0]  w0_x, w1_x;
  logic [8:0]  w0_y, w1_y;
  logic [23:0] w0_rgb, w1_rgb;
  logic        w0_ready, w1_ready;
  logic        swap_req, frame_end;
  logic        front, swap_done;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic [23:0] mem_rdata;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [23:0] pre_data;
  logic [23:0] ram [0:65535];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.WIDTH(160), .HEIGHT(120), .ADDR_W(16)) dut (
    .CLOCK_50(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_valid(disp_valid), .disp_rgb(disp_rgb),
    .w0_req(w0_req), .w0_x(w0_x), .w0_y(w0_y), .w0_rgb(w0_rgb), .w0_ready(w0_ready),
    .w1_req(w1_req), .w1_x(w1_x), .w1_y(w1_y), .w1_rgb(w1_rgb), .w1_ready(w1_ready),
    .swap_req(swap_req), .frame_end(frame_end), .front(front), .swap_done(swap_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // RAM with one-cycle read latency; bench preload takes precedence
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (mem_addr !== 16'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (mem_we !== 1'b0 || mem_wdata !== 24'd0) begin bad++; $display("FAIL reset_we got=%b/%h exp=0", mem_we, mem_wdata); end
    total++; if (disp_valid !== 1'b0 || disp_rgb !== 24'd0) begin bad++; $display("FAIL reset_disp got=%b/%h exp=0", disp_valid, disp_rgb); end
    total++; if (front !== 1'b0 || swap_done !== 1'b0) begin bad++; $display("FAIL reset_front got=%b/%b exp=0/0", front, swap_done); end
    #3 reset_n = 1'b1;
  endtask

  task automatic test_read();
    cyc(); disp_req = 1'b1; disp_x = 10'd3; disp_y = 9'd2;
    cyc(); disp_req = 1'b0; #1;
    total++; if (mem_addr !== 16'd323 || mem_we !== 1'b0) begin bad++; $display("FAIL read_addr got=%0d/%b exp=323/0", mem_addr, mem_we); end
    cyc();
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL read_early got=%b exp=0", disp_valid); end
    cyc();
    total++; if (disp_valid !== 1'b1 || disp_rgb !== 24'hABCDEF) begin bad++; $display("FAIL read_data got=%b/%h exp=1/abcdef", disp_valid, disp_rgb); end
    cyc();
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL read_late got=%b exp=0", disp_valid); end
  endtask

  task automatic test_round_robin();
    logic exp_w0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_a [4] = '{16'h8000, 16'h8001, 16'h8000, 16'h8001};
    w0_x = 10'd0; w0_y = 9'd0; w0_rgb = 24'h111111;
    w1_x = 10'd1; w1_y = 9'd0; w1_rgb = 24'h222222;
    for (int i = 0; i < 5; i++) begin
      cyc();
      w0_req = (i < 4); w1_req = (i < 4);
      #1;
      if (i > 0) begin
        total++;
        if (mem_we !== 1'b1 || mem_addr !== exp_a[i-1] || mem_addr[15] !== 1'b1)
          begin bad++; $display("FAIL rr_mem%0d got=%b/%h exp=1/%h", i-1, mem_we, mem_addr, exp_a[i-1]); end
      end
      if (i < 4) begin
        total++;
        if (w0_ready !== exp_w0[i] || w1_ready !== ~exp_w0[i])
          begin bad++; $display("FAIL rr_grant%0d got=%b%b exp=%b%b", i, w0_ready, w1_ready, exp_w0[i], ~exp_w0[i]); end
      end
    end
  endtask

  task automatic test_priority();
    w0_x = 10'd4; w0_y = 9'd0; w0_rgb = 24'h333333;
    for (int i = 0; i < 4; i++) begin
      cyc();
      disp_req = (i < 3); disp_x = 10'd0; disp_y = 9'd0; w0_req = 1'b1;
      #1;
      total++;
      if (w0_ready !== (i == 3)) begin bad++; $display("FAIL prio%0d got=%b exp=%b", i, w0_ready, (i == 3)); end
    end
    cyc(); w0_req = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
  endtask

  task automatic test_out_of_range();
    cyc(); w1_req = 1'b1; w1_x = 10'd160; w1_y = 9'd0; w1_rgb = 24'h123456; #1;
    total++; if (w1_ready !== 1'b1 || w0_ready !== 1'b0) begin bad++; $display("FAIL oor_wr_ready got=%b/%b exp=1/0", w1_ready, w0_ready); end
    cyc(); w1_req = 1'b0; disp_req = 1'b1; disp_x = 10'd0; disp_y = 9'd120; #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL oor_wr_we got=%b exp=0", mem_we); end
    cyc(); disp_req = 1'b0; #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL oor_rd_we got=%b exp=0", mem_we); end
    cyc();
    cyc();
    total++; if (disp_valid !== 1'b1 || disp_rgb !== 24'd0) begin bad++; $display("FAIL oor_rd_data got=%b/%h exp=1/0", disp_valid, disp_rgb); end
  endtask

  task automatic test_swap();
    cyc(); swap_req = 1'b1; frame_end = 1'b1;
    cyc(); swap_req = 1'b0; frame_end = 1'b0;
    total++; if (front !== 1'b0 || swap_done !== 1'b0) begin bad++; $display("FAIL swap_same got=%b/%b exp=0/0", front, swap_done); end
    for (int i = 2; i < 10; i++) begin
      cyc();
      total++; if (front !== 1'b0 || swap_done !== 1'b0) begin bad++; $display("FAIL swap_wait%0d got=%b/%b exp=0/0", i, front, swap_done); end
    end
    cyc(); frame_end = 1'b1;
    cyc(); frame_end = 1'b0;
    total++; if (front !== 1'b1 || swap_done !== 1'b1) begin bad++; $display("FAIL swap_edge got=%b/%b exp=1/1", front, swap_done); end
    cyc();
    total++; if (front !== 1'b1 || swap_done !== 1'b0) begin bad++; $display("FAIL swap_after got=%b/%b exp=1/0", front, swap_done); end
    disp_req = 1'b1; disp_x = 10'd0; disp_y = 9'd0;
    cyc(); disp_req = 1'b0; #1;
    total++; if (mem_addr !== 16'h8000) begin bad++; $display("FAIL swap_rd_addr got=%h exp=8000", mem_addr); end
    cyc();
    cyc();
    total++; if (disp_valid !== 1'b1 || disp_rgb !== 24'h111111) begin bad++; $display("FAIL swap_rd_data got=%b/%h exp=1/111111", disp_valid, disp_rgb); end
  endtask

  task automatic test_reset_midburst();
    cyc(); w0_req = 1'b1; w0_x = 10'd2; w0_y = 9'd0; #1;
    total++; if (w0_ready !== 1'b1) begin bad++; $display("FAIL rst_pre_w0 got=%b exp=1", w0_ready); end
    cyc(); w0_req = 1'b0; disp_req = 1'b1; disp_x = 10'd5; disp_y = 9'd5;
    cyc();
    cyc(); disp_req = 1'b0; #1;
    total++; if (mem_addr !== 16'h8325) begin bad++; $display("FAIL rst_pre_addr got=%h exp=8325", mem_addr); end
    #1 reset_n = 1'b0; #1;
    total++; if (mem_addr !== 16'd0 || mem_we !== 1'b0 || mem_wdata !== 24'd0) begin bad++; $display("FAIL rst_mem got=%h/%b/%h exp=0", mem_addr, mem_we, mem_wdata); end
    total++; if (disp_valid !== 1'b0 || disp_rgb !== 24'd0 || front !== 1'b0 || swap_done !== 1'b0)
      begin bad++; $display("FAIL rst_out got=%b/%h/%b/%b exp=0", disp_valid, disp_rgb, front, swap_done); end
    cyc();
    cyc(); #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL rst_ghost%0d got=%b exp=0", i, disp_valid); end
    end
    w0_req = 1'b1; w1_req = 1'b1; #1;
    total++; if (w0_ready !== 1'b1 || w1_ready !== 1'b0) begin bad++; $display("FAIL rst_rr got=%b%b exp=10", w0_ready, w1_ready); end
    cyc(); w0_req = 1'b0; w1_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    disp_req = 1'b0; disp_x = 10'd0; disp_y = 9'd0;
    w0_req = 1'b0; w0_x = 10'd0; w0_y = 9'd0; w0_rgb = 24'd0;
    w1_req = 1'b0; w1_x = 10'd0; w1_y = 9'd0; w1_rgb = 24'd0;
    swap_req = 1'b0; frame_end = 1'b0;
    pre_we = 1'b1; pre_addr = 16'd323; pre_data = 24'hABCDEF;
    cyc(); pre_addr = 16'd19200; pre_data = 24'h5A5A5A;
    cyc(); pre_we = 1'b0;
    test_reset();
    test_read();
    test_round_robin();
    test_priority();
    test_out_of_range();
    test_swap();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
